// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: conditions N raw pushbuttons for the calculator FSM.
// Each channel runs a 2-FF synchroniser, a debounce counter and a 4-state FSM.
// The outputs are debounced levels, 1-cycle press and release pulses, and a
// single-button press vector.
// Optional feature: define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module btn_debounce_pulse #(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_RATE   = 5000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_single,
    output logic         busy
);

    localparam int MAX_DR  = (DEB_CYCLES > RPT_DELAY) ? DEB_CYCLES : RPT_DELAY;
    localparam int CNT_MAX = (MAX_DR > RPT_RATE) ? MAX_DR : RPT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    // The hold counter counts up from 0 after entering PRESSED. Reloading it with
    // DELAY-RATE after each repeat makes the later repeats RATE cycles apart.
    // This needs RPT_DELAY >= RPT_RATE >= 1.
    localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(RPT_DELAY - RPT_RATE);
`endif

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    state_t           state     [N];
    state_t           state_nxt [N];
    logic [CNT_W-1:0] cnt       [N];
    logic [CNT_W-1:0] cnt_nxt   [N];
    logic [N-1:0]     level_nxt;
    logic [N-1:0]     press_nxt;
    logic [N-1:0]     release_nxt;
`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold      [N];
    logic [CNT_W-1:0] hold_nxt  [N];
`endif

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Two-stage synchroniser on the raw asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Per-channel next state, debounce counter and output pulse decisions.
    always_comb begin
        level_nxt   = btn_level;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < N; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
`ifdef BTN_AUTOREPEAT_EN
            hold_nxt[i]  = '0;
`endif
            case (state[i])
                RELEASED: begin
                    if (s2[i]) begin
                        state_nxt[i] = PRESS_PEND;
                        cnt_nxt[i]   = CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!s2[i]) begin
                        state_nxt[i] = RELEASED;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        state_nxt[i] = PRESSED;
                        level_nxt[i] = 1'b1;
                        press_nxt[i] = 1'b1;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i]   = sat_inc(cnt[i]);
                    end
                end
                PRESSED: begin
                    if (!s2[i]) begin
                        state_nxt[i] = RELEASE_PEND;
                        cnt_nxt[i]   = CNT_W'(1);
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (hold[i] == RPT_FIRST) begin
                        press_nxt[i] = 1'b1;
                        hold_nxt[i]  = RPT_RELOAD;
                    end else begin
                        hold_nxt[i]  = sat_inc(hold[i]);
                    end
`endif
                end
                RELEASE_PEND: begin
                    if (s2[i]) begin
                        state_nxt[i]   = PRESSED;
                        cnt_nxt[i]     = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        state_nxt[i]   = RELEASED;
                        level_nxt[i]   = 1'b0;
                        release_nxt[i] = 1'b1;
                        cnt_nxt[i]     = '0;
                    end else begin
                        cnt_nxt[i]     = sat_inc(cnt[i]);
                    end
                end
                default: begin
                    state_nxt[i] = RELEASED;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // State, counter and registered-output update. Reset discards any qualification in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                hold[i]  <= '0;
`endif
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
`ifdef BTN_AUTOREPEAT_EN
                hold[i]  <= hold_nxt[i];
`endif
            end
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    // A press counts as single only when its own button is the only level high.
    always_comb begin
        btn_single = '0;
        for (int i = 0; i < N; i++) begin
            btn_single[i] = btn_press[i] & (btn_level == (N'(1) << i));
        end
    end

    // busy is high while any channel is qualifying an edge.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            busy = busy | (state[i] == PRESS_PEND) | (state[i] == RELEASE_PEND);
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse (DEB_CYCLES=8, RPT_DELAY=20, RPT_RATE=6).
// The stimulus queues the expected pulse events and level snapshots, keyed by cycle.
// The monitor pops an event each time the DUT pulses and pops snapshots on their cycle.
module tb_btn_debounce_pulse;

    localparam int N   = 4;
    localparam int DEB = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_single;
    logic         busy;

    typedef struct {
        int       cyc;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] single;
        logic       busy;
    } exp_t;

    exp_t evq[$];
    exp_t snq[$];
    int   cyc;
    bit   done;

    btn_debounce_pulse #(
        .N(N), .DEB_CYCLES(DEB), .RPT_DELAY(20), .RPT_RATE(6)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release),
        .btn_single(btn_single), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] sg, input logic [3:0] lv);
        exp_t e;
        e.cyc = c; e.press = pr; e.rel = rl; e.single = sg; e.level = lv; e.busy = 1'b0;
        evq.push_back(e);
    endtask

    task automatic push_snap(input int c, input logic [3:0] lv, input logic b);
        exp_t e;
        e.cyc = c; e.press = '0; e.rel = '0; e.single = '0; e.level = lv; e.busy = b;
        snq.push_back(e);
    endtask

    // Stimulus: directed scenarios with hand-computed event cycles.
    initial begin
        int c;
        cyc    = 0;
        done   = 1'b0;
        rst    = 1'b1;
        btn_in = '0;
        tick(3);
        push_snap(cyc, 4'b0000, 1'b0);
        rst = 1'b0;
        tick(2);

        // clean single press of button 0 and its release
        c = cyc; btn_in = 4'b0001;
        push_snap(c + 5, 4'b0000, 1'b1);
        push_ev(c + DEB + 2, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        push_snap(c + 11, 4'b0001, 1'b0);
        tick(15);
        c = cyc; btn_in = 4'b0000;
        push_snap(c + 6, 4'b0001, 1'b1);
        push_ev(c + DEB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tick(14);

        // bouncing press: 1,0,1 every 3 cycles, then steady
        c = cyc; btn_in = 4'b0001;
        tick(3); btn_in = 4'b0000;
        tick(3); btn_in = 4'b0001;
        push_ev(c + 6 + DEB + 2, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        tick(14);
        c = cyc; btn_in = 4'b0000;
        push_ev(c + DEB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tick(14);

        // two buttons qualifying in the same cycle
        c = cyc; btn_in = 4'b0011;
        push_ev(c + DEB + 2, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        tick(14);
        c = cyc; btn_in = 4'b0000;
        push_ev(c + DEB + 2, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
        tick(14);

        // press of button 1 while button 0 is held
        c = cyc; btn_in = 4'b0001;
        push_ev(c + DEB + 2, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        tick(14);
        c = cyc; btn_in = 4'b0011;
        push_ev(c + DEB + 2, 4'b0010, 4'b0000, 4'b0000, 4'b0011);
        tick(14);
        c = cyc; btn_in = 4'b0000;
        push_ev(c + DEB + 2, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
        tick(14);

        // hold button 2, then clean release
        c = cyc; btn_in = 4'b0100;
        push_ev(c + DEB + 2, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        tick(20);
        c = cyc; btn_in = 4'b0000;
        push_snap(c + 9, 4'b0100, 1'b1);
        push_ev(c + DEB + 2, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        push_snap(c + 11, 4'b0000, 1'b0);
        tick(14);

        // reset at count 5 of a press; the held button requalifies afterwards
        btn_in = 4'b0001;
        tick(7);
        rst = 1'b1;
        tick(2);
        push_snap(cyc, 4'b0000, 1'b0);
        rst = 1'b0;
        push_ev(cyc + DEB + 2, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        tick(14);
        c = cyc; btn_in = 4'b0000;
        push_ev(c + DEB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tick(14);

        // long hold of button 3 (repeats only with auto-repeat built in)
        c = cyc; btn_in = 4'b1000;
        push_ev(c + DEB + 2, 4'b1000, 4'b0000, 4'b1000, 4'b1000);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 6; k++) begin
            push_ev(c + 30 + 6 * k, 4'b1000, 4'b0000, 4'b1000, 4'b1000);
        end
`endif
        tick(60);
        c = cyc; btn_in = 4'b0000;
        push_ev(c + DEB + 2, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        tick(14);

        done = 1'b1;
    end

    // Monitor: compares DUT pulses and snapshots against the queued expectations.
    initial begin
        int n_chk;
        int n_fail;
        exp_t e;
        n_chk  = 0;
        n_fail = 0;
        forever begin
            @(negedge clk);
            while (snq.size() > 0 && snq[0].cyc <= cyc) begin
                e = snq.pop_front();
                n_chk++;
                if (e.cyc != cyc || btn_level !== e.level || btn_press !== e.press ||
                    btn_release !== e.rel || btn_single !== e.single || busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL snapshot cyc=%0d (due %0d): actual lvl=%b prs=%b rel=%b sgl=%b busy=%b required lvl=%b prs=%b rel=%b sgl=%b busy=%b",
                             cyc, e.cyc, btn_level, btn_press, btn_release, btn_single, busy,
                             e.level, e.press, e.rel, e.single, e.busy);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_event cyc=%0d: actual none required prs=%b rel=%b at cyc %0d",
                         cyc, e.press, e.rel, e.cyc);
            end
            if ((btn_press | btn_release) != '0) begin
                n_chk++;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    e = evq.pop_front();
                    if (btn_press !== e.press || btn_release !== e.rel ||
                        btn_single !== e.single || btn_level !== e.level) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d: actual prs=%b rel=%b sgl=%b lvl=%b required prs=%b rel=%b sgl=%b lvl=%b",
                                 cyc, btn_press, btn_release, btn_single, btn_level,
                                 e.press, e.rel, e.single, e.level);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d: actual prs=%b rel=%b required no pulse",
                             cyc, btn_press, btn_release);
                end
            end
            if (done || cyc > 5000) begin
                if (!done) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL timeout cyc=%0d: actual running required finished", cyc);
                end
                while (evq.size() > 0) begin
                    e = evq.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL leftover_event: actual none required prs=%b rel=%b at cyc %0d",
                             e.press, e.rel, e.cyc);
                end
                while (snq.size() > 0) begin
                    e = snq.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL leftover_snapshot: actual unchecked required check at cyc %0d", e.cyc);
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

endmodule
